// File: rtl/dlx_mem_pkg.sv
// rtl/dlx_mem_pkg.sv - shared encodings and default widths for the DLX data RAM arbiter
package dlx_mem_pkg;

  localparam int DLX_DATA_W = 32;
  localparam int DLX_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dlx_mem_arb_pick.sv
// rtl/dlx_mem_arb_pick.sv - CPU-priority winner select with DBG starvation override
module dlx_mem_arb_pick
  import dlx_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             cpu_req,
  input  logic             dbg_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output owner_t           winner
);

  // CPU wins unless a DBG request has already lost STARVE_MAX arbitrations in a row
  always_comb begin
    winner = OWN_NONE;
    if (cpu_req && !(dbg_req && (starve_cnt == CNT_W'(STARVE_MAX)))) begin
      winner = OWN_CPU;
    end else if (dbg_req) begin
      winner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// rtl/dlx_mem_arbiter.sv - shares the single-port data RAM between the DLX pipeline and the debug port
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int DATA_W     = DLX_DATA_W,
  parameter int ADDR_W     = DLX_ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t       state;
  owner_t           owner;
  owner_t           winner;
  logic [CNT_W-1:0] starve_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             done_cycle;

  // The requester still holds its old request during its done cycle, so IDLE
  // must not arbitrate then or the finished access would be issued twice.
  assign done_cycle = cpu_done | dbg_ack;

  // The pipeline advances on the same edge that delivers data
  assign cpu_stall = cpu_req & ~cpu_done;

  dlx_mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .starve_cnt (starve_cnt),
    .winner     (winner)
  );

  // Access FSM: arbitrate, drive the RAM, wait out read latency, return data with a done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dbg_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!done_cycle) begin
            if (!dbg_req || winner == OWN_DBG) begin
              starve_cnt <= '0;
            end else if (winner == OWN_CPU && starve_cnt != CNT_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            if (winner == OWN_CPU) begin
              ram_addr  <= cpu_addr;
              ram_we    <= cpu_we;
              ram_wdata <= cpu_wdata;
              owner     <= OWN_CPU;
              state     <= ST_ACCESS;
            end else if (winner == OWN_DBG) begin
              ram_addr  <= dbg_addr;
              ram_we    <= dbg_we;
              ram_wdata <= dbg_wdata;
              owner     <= OWN_DBG;
              state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (ram_we) begin
            ram_we   <= 1'b0;
            cpu_done <= (owner == OWN_CPU);
            dbg_ack  <= (owner == OWN_DBG);
            owner    <= OWN_NONE;
            state    <= ST_IDLE;
          end else begin
            lat_cnt <= LAT_W'(RD_LAT - 1);
            state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            if (owner == OWN_CPU) begin
              cpu_rdata <= ram_rdata;
              cpu_done  <= 1'b1;
            end else if (owner == OWN_DBG) begin
              dbg_rdata <= ram_rdata;
              dbg_ack   <= 1'b1;
            end
            owner <= OWN_NONE;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb/tb_dlx_mem_arbiter.sv - self-checking bench for dlx_mem_arbiter at RD_LAT=1 and RD_LAT=3
module tb_dlx_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset     [2];
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_done  [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_wdata [2];
    logic [31:0] dbg_rdata [2];
    logic        dbg_ack   [2];
    logic [31:0] ram_addr  [2];
    logic        ram_we    [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    dlx_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1), .STARVE_MAX(4)) u0 (
        .clock(clock), .reset(reset[0]),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_done(cpu_done[0]), .cpu_stall(cpu_stall[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
        .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    dlx_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3), .STARVE_MAX(4)) u1 (
        .clock(clock), .reset(reset[1]),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_done(cpu_done[1]), .cpu_stall(cpu_stall[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
        .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    bit [31:0] ram0 [256];
    bit [31:0] ram1 [256];
    logic [31:0] rd0 = '0, p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clock) begin
        if (ram_we[0]) ram0[ram_addr[0][9:2]] <= ram_wdata[0];
        rd0 <= ram0[ram_addr[0][9:2]];
        if (ram_we[1]) ram1[ram_addr[1][9:2]] <= ram_wdata[1];
        p1 <= ram1[ram_addr[1][9:2]];
        p2 <= p1;
        p3 <= p2;
    end
    assign ram_rdata[0] = rd0;
    assign ram_rdata[1] = p3;

    logic [31:0] ref0 [logic [31:0]];
    logic [31:0] ref1 [logic [31:0]];
    int cpu_cycs [$];

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        if (k == 0) return ref0.exists(a) ? ref0[a] : 32'h0;
        return ref1.exists(a) ? ref1[a] : 32'h0;
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d);
        if (k == 0) ref0[a] = d;
        else ref1[a] = d;
    endtask

    function automatic int rd_lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check_zero(input int k);
        chk("rst_cpu_done", cpu_done[k], 1'b0);
        chk("rst_dbg_ack", dbg_ack[k], 1'b0);
        chk("rst_ram_we", ram_we[k], 1'b0);
        chk("rst_ram_addr", ram_addr[k], 32'h0);
        chk("rst_ram_wdata", ram_wdata[k], 32'h0);
        chk("rst_cpu_rdata", cpu_rdata[k], 32'h0);
        chk("rst_dbg_rdata", dbg_rdata[k], 32'h0);
    endtask

    task automatic do_access(input int k, input bit dbg, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit chk_lat,
                             output logic [31:0] rdata_o, output int done_cyc);
        int n;
        bit seen;
        bit obs_done;
        logic [31:0] prev_rdata;
        n = 0;
        seen = 1'b0;
        done_cyc = -1;
        prev_rdata = dbg ? dbg_rdata[k] : cpu_rdata[k];
        if (dbg) begin
            dbg_req[k] = 1'b1; dbg_we[k] = we; dbg_addr[k] = addr; dbg_wdata[k] = wdata;
        end else begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
        end
        while (!seen && n < 60) begin
            @(negedge clock);
            n++;
            obs_done = dbg ? dbg_ack[k] : cpu_done[k];
            if (obs_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                if (!dbg) begin
                    chk("stall_while_waiting", cpu_stall[k], 1'b1);
                end
                chk("rdata_stable_before_done", (dbg ? dbg_rdata[k] : cpu_rdata[k]), prev_rdata);
            end
        end
        chk("done_seen", seen, 1'b1);
        if (!dbg) begin
            chk("stall_low_in_done", cpu_stall[k], 1'b0);
        end
        if (chk_lat) begin
            chk("latency", n, (we ? 2 : 2 + rd_lat_of(k)));
        end
        rdata_o = dbg ? dbg_rdata[k] : cpu_rdata[k];
        if (we) model_write(k, addr, wdata);
        else begin
            chk("read_data", rdata_o, model_read(k, addr));
        end
        if (dbg) dbg_req[k] = 1'b0;
        else cpu_req[k] = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] rd;
        int dc, prev_dc, dbg_dc, wins;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check_zero(k);
            chk("rst_cpu_stall", cpu_stall[k], 1'b0);
            reset[k] = 1'b0;
        end
        @(negedge clock);

        do_access(0, 1'b0, 1'b1, 32'h8, 32'h1E, 1'b1, rd, dc);
        do_access(0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, rd, dc);
        chk("cpu_read_0x8", rd, 32'h1E);

        prev_dc = 0;
        for (int i = 0; i < 8; i++) begin
            do_access(0, 1'b1, 1'b1, 32'(i * 4), 32'(i * 4 + 1), 1'b1, rd, dc);
            if (i > 0) begin
                chk("ack_spacing", dc - prev_dc, 3);
            end
            prev_dc = dc;
        end
        for (int i = 0; i < 8; i++) begin
            do_access(0, 1'b0, 1'b0, 32'(i * 4), 32'h0, 1'b1, rd, dc);
        end

        dbg_dc = -1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int cdc;
                    logic [31:0] crd;
                    do_access(0, 1'b0, 1'b1, 32'(32'h100 + i * 4), 32'(32'hC0DE0000 + i), 1'b0, crd, cdc);
                    cpu_cycs.push_back(cdc);
                end
            end
            begin
                logic [31:0] drd;
                do_access(0, 1'b1, 1'b1, 32'h40, 32'hDEAD, 1'b0, drd, dbg_dc);
                chk("starve_cnt_cleared", u0.starve_cnt, 3'd0);
            end
        join
        wins = 0;
        foreach (cpu_cycs[j]) if (cpu_cycs[j] < dbg_dc) wins++;
        chk("cpu_wins_before_dbg", wins, 4);
        do_access(0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, rd, dc);
        chk("cpu_read_0x40", rd, 32'hDEAD);
        do_access(0, 1'b0, 1'b0, 32'h114, 32'h0, 1'b1, rd, dc);

        do_access(1, 1'b0, 1'b1, 32'h20, 32'hABCD0001, 1'b1, rd, dc);
        do_access(1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, rd, dc);
        chk("lat3_read", rd, 32'hABCD0001);

        dbg_req[1] = 1'b1; dbg_we[1] = 1'b0; dbg_addr[1] = 32'h20;
        repeat (3) begin
            @(negedge clock);
            chk("no_ack_before_reset", dbg_ack[1], 1'b0);
        end
        reset[1] = 1'b1;
        dbg_req[1] = 1'b0;
        @(negedge clock);
        check_zero(1);
        reset[1] = 1'b0;
        @(negedge clock);
        chk("no_ack_after_reset", dbg_ack[1], 1'b0);
        do_access(1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, rd, dc);

        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'h77;
        @(negedge clock);
        reset[0] = 1'b1;
        cpu_req[0] = 1'b0;
        @(negedge clock);
        chk("no_done_on_reset_write", cpu_done[0], 1'b0);
        reset[0] = 1'b0;
        model_write(0, 32'h10, 32'h77);
        @(negedge clock);
        chk("no_done_after_reset_write", cpu_done[0], 1'b0);
        do_access(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, rd, dc);
        chk("write_survives_reset", rd, 32'h77);

        for (int i = 0; i < 40; i++) begin
            int k;
            bit dbg, we;
            logic [31:0] a, d;
            k   = int'($urandom_range(0, 1));
            dbg = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63) * 4);
            d   = $urandom;
            do_access(k, dbg, we, a, d, 1'b1, rd, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
